// File: rtl/alarm_unit.sv
// Alarm comparator and ring/snooze controller fed by the time-of-day stage.
// Define ALARM_UNIT_SNOOZE_LIMIT_EN to cap snoozes at three per alarm.
module alarm_unit #(
  parameter int unsigned SNOOZE_MINS = 9,
  parameter int unsigned RING_MINS   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] hours,
  input  logic [5:0] mins,
  input  logic       pm,
  input  logic       alarm_on,
  input  logic       alarm_set_en,
  input  logic [3:0] alarm_set_hours,
  input  logic [5:0] alarm_set_mins,
  input  logic       alarm_set_pm,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       ring,
  output logic       snoozing,
  output logic [3:0] alarm_hours,
  output logic [5:0] alarm_mins,
  output logic       alarm_pm
);

  typedef enum logic [1:0] {
    IDLE,
    RINGING,
    SNOOZE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] ring_cnt_q, ring_cnt_d;
  logic [3:0] snz_cnt_q, snz_cnt_d;
  logic       tick_q;
  logic [3:0] al_hours_q;
  logic [5:0] al_mins_q;
  logic       al_pm_q;
  logic       match;
  logic       trigger;
  logic       snz_ok;

  // Delayed tick: only a minute rollover, never a set, can raise trigger
  assign match   = (hours == al_hours_q) &&
                   (mins == al_mins_q) &&
                   (pm == al_pm_q);
  assign trigger = match & tick_q;

`ifdef ALARM_UNIT_SNOOZE_LIMIT_EN
  logic [1:0] scnt_q, scnt_d;
  logic       snz_inc;

  assign snz_ok = (scnt_q != 2'd3);

  always_comb begin
    scnt_d = scnt_q;
    if (state_d == IDLE) begin
      scnt_d = 2'd0;
    end else if (snz_inc) begin
      scnt_d = scnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scnt_q <= 2'd0;
    end else begin
      scnt_q <= scnt_d;
    end
  end
`else
  assign snz_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
`ifdef ALARM_UNIT_SNOOZE_LIMIT_EN
    snz_inc    = 1'b0;
`endif
    if (!alarm_on) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_d    = RINGING;
            ring_cnt_d = 4'(RING_MINS);
          end
        end
        RINGING: begin
          if (dismiss) begin
            state_d = IDLE;
          end else if (snooze && snz_ok) begin
            state_d   = SNOOZE;
            snz_cnt_d = 4'(SNOOZE_MINS);
`ifdef ALARM_UNIT_SNOOZE_LIMIT_EN
            snz_inc   = 1'b1;
`endif
          end else if (tick) begin
            if (ring_cnt_q <= 4'd1) begin
              state_d = IDLE;
            end else begin
              ring_cnt_d = ring_cnt_q - 4'd1;
            end
          end
        end
        SNOOZE: begin
          if (dismiss) begin
            state_d = IDLE;
          end else if (tick) begin
            if (snz_cnt_q <= 4'd1) begin
              state_d    = RINGING;
              ring_cnt_d = 4'(RING_MINS);
            end else begin
              snz_cnt_d = snz_cnt_q - 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ring_cnt_q <= 4'd0;
      snz_cnt_q  <= 4'd0;
      tick_q     <= 1'b0;
      al_hours_q <= 4'd12;
      al_mins_q  <= 6'd0;
      al_pm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      tick_q     <= tick;
      if (alarm_set_en) begin
        al_hours_q <= alarm_set_hours;
        al_mins_q  <= alarm_set_mins;
        al_pm_q    <= alarm_set_pm;
      end
    end
  end

  assign ring        = (state_q == RINGING);
  assign snoozing    = (state_q == SNOOZE);
  assign alarm_hours = al_hours_q;
  assign alarm_mins  = al_mins_q;
  assign alarm_pm    = al_pm_q;

endmodule

// File: tb/tb_alarm_unit.sv
// Directed bench for alarm_unit: trigger latency, timeout, snooze,
// set-path immunity, alarm_on override and asynchronous reset.
module tb_alarm_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] hours;
  logic [5:0] mins;
  logic       pm;
  logic       alarm_on;
  logic       alarm_set_en;
  logic [3:0] alarm_set_hours;
  logic [5:0] alarm_set_mins;
  logic       alarm_set_pm;
  logic       snooze;
  logic       dismiss;
  logic       ring;
  logic       snoozing;
  logic [3:0] alarm_hours;
  logic [5:0] alarm_mins;
  logic       alarm_pm;

  int n_cmp = 0;
  int n_bad = 0;

  alarm_unit dut (
    .clk(clk), .reset(reset), .tick(tick),
    .hours(hours), .mins(mins), .pm(pm),
    .alarm_on(alarm_on), .alarm_set_en(alarm_set_en),
    .alarm_set_hours(alarm_set_hours),
    .alarm_set_mins(alarm_set_mins),
    .alarm_set_pm(alarm_set_pm),
    .snooze(snooze), .dismiss(dismiss),
    .ring(ring), .snoozing(snoozing),
    .alarm_hours(alarm_hours), .alarm_mins(alarm_mins),
    .alarm_pm(alarm_pm)
  );

  always #5 clk = ~clk;

  task automatic set_alarm(input logic [3:0] h, input logic [5:0] m,
                           input logic p);
    @(negedge clk);
    alarm_set_en = 1'b1;
    alarm_set_hours = h;
    alarm_set_mins = m;
    alarm_set_pm = p;
    @(posedge clk);
    #1 alarm_set_en = 1'b0;
  endtask

  // Clock stage model: time advances on the edge that samples tick
  task automatic tick_next();
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    mins = mins + 6'd1;
  endtask

  task automatic pulse_snooze();
    @(negedge clk);
    snooze = 1'b1;
    @(posedge clk);
    #1 snooze = 1'b0;
  endtask

  task automatic pulse_dismiss();
    @(negedge clk);
    dismiss = 1'b1;
    @(posedge clk);
    #1 dismiss = 1'b0;
  endtask

  task automatic ring_up(input logic [3:0] h, input logic [5:0] m);
    set_alarm(h, m, 1'b0);
    @(negedge clk);
    hours = h;
    mins = m - 6'd1;
    pm = 1'b0;
    tick_next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    n_cmp++;
    if ({ring, snoozing} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_out ring/snoozing=%b want 00", {ring, snoozing});
    end
    n_cmp++;
    if ({alarm_hours, alarm_mins, alarm_pm} !== {4'd12, 6'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_alarm got %0d:%0d pm%b want 12:0 pm0",
               alarm_hours, alarm_mins, alarm_pm);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_match();
    set_alarm(4'd6, 6'd30, 1'b0);
    @(negedge clk);
    hours = 4'd6;
    mins = 6'd29;
    pm = 1'b0;
    tick_next();
    @(negedge clk);
    n_cmp++;
    if (ring !== 1'b0) begin
      n_bad++;
      $display("FAIL match_early ring=%b want 0", ring);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (ring !== 1'b1) begin
      n_bad++;
      $display("FAIL match_ring ring=%b want 1", ring);
    end
  endtask

  task automatic test_timeout();
    for (int i = 1; i <= 4; i++) begin
      tick_next();
      n_cmp++;
      if (ring !== 1'b1) begin
        n_bad++;
        $display("FAIL timeout_hold tick%0d ring=%b want 1", i, ring);
      end
    end
    tick_next();
    n_cmp++;
    if (ring !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_drop ring=%b want 0", ring);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({ring, snoozing} !== 2'b00) begin
      n_bad++;
      $display("FAIL timeout_idle ring/snoozing=%b want 00", {ring, snoozing});
    end
  endtask

  task automatic test_snooze();
    ring_up(4'd6, 6'd40);
    n_cmp++;
    if (ring !== 1'b1) begin
      n_bad++;
      $display("FAIL snz_ringup ring=%b want 1", ring);
    end
    pulse_snooze();
    n_cmp++;
    if ({ring, snoozing} !== 2'b01) begin
      n_bad++;
      $display("FAIL snz_enter ring/snoozing=%b want 01", {ring, snoozing});
    end
    repeat (4) tick_next();
    pulse_snooze();
    repeat (4) tick_next();
    n_cmp++;
    if ({ring, snoozing} !== 2'b01) begin
      n_bad++;
      $display("FAIL snz_8tick ring/snoozing=%b want 01", {ring, snoozing});
    end
    tick_next();
    n_cmp++;
    if ({ring, snoozing} !== 2'b10) begin
      n_bad++;
      $display("FAIL snz_9tick ring/snoozing=%b want 10", {ring, snoozing});
    end
    @(negedge clk);
    dismiss = 1'b1;
    snooze = 1'b1;
    @(posedge clk);
    #1 dismiss = 1'b0;
    snooze = 1'b0;
    n_cmp++;
    if ({ring, snoozing} !== 2'b00) begin
      n_bad++;
      $display("FAIL snz_dismiss ring/snoozing=%b want 00", {ring, snoozing});
    end
  endtask

  task automatic test_snooze_limit();
    ring_up(4'd7, 6'd10);
    for (int k = 1; k <= 3; k++) begin
      pulse_snooze();
      n_cmp++;
      if ({ring, snoozing} !== 2'b01) begin
        n_bad++;
        $display("FAIL lim_snz%0d ring/snoozing=%b want 01", k,
                 {ring, snoozing});
      end
      repeat (9) tick_next();
      n_cmp++;
      if ({ring, snoozing} !== 2'b10) begin
        n_bad++;
        $display("FAIL lim_back%0d ring/snoozing=%b want 10", k,
                 {ring, snoozing});
      end
    end
    pulse_snooze();
    repeat (2) @(posedge clk);
    #1;
`ifdef ALARM_UNIT_SNOOZE_LIMIT_EN
    n_cmp++;
    if ({ring, snoozing} !== 2'b10) begin
      n_bad++;
      $display("FAIL lim_4th ring/snoozing=%b want 10", {ring, snoozing});
    end
`else
    n_cmp++;
    if ({ring, snoozing} !== 2'b01) begin
      n_bad++;
      $display("FAIL lim_4th ring/snoozing=%b want 01", {ring, snoozing});
    end
`endif
    pulse_dismiss();
    n_cmp++;
    if ({ring, snoozing} !== 2'b00) begin
      n_bad++;
      $display("FAIL lim_dismiss ring/snoozing=%b want 00", {ring, snoozing});
    end
  endtask

  task automatic test_set_path();
    set_alarm(4'd12, 6'd0, 1'b0);
    @(negedge clk);
    hours = 4'd12;
    mins = 6'd0;
    pm = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    set_alarm(4'd12, 6'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (ring !== 1'b0) begin
      n_bad++;
      $display("FAIL setpath ring=%b want 0", ring);
    end
    @(negedge clk);
    hours = 4'd11;
    mins = 6'd59;
    pm = 1'b1;
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    hours = 4'd12;
    mins = 6'd0;
    pm = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (ring !== 1'b1) begin
      n_bad++;
      $display("FAIL midnight ring=%b want 1", ring);
    end
    set_alarm(4'd5, 6'd5, 1'b1);
    n_cmp++;
    if ({ring, alarm_hours, alarm_mins, alarm_pm} !==
        {1'b1, 4'd5, 6'd5, 1'b1}) begin
      n_bad++;
      $display("FAIL load_ring ring=%b alarm=%0d:%0d pm%b want 1 5:5 pm1",
               ring, alarm_hours, alarm_mins, alarm_pm);
    end
    @(negedge clk);
    alarm_on = 1'b0;
    dismiss = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (ring !== 1'b0) begin
      n_bad++;
      $display("FAIL alarm_off ring=%b want 0", ring);
    end
    @(negedge clk);
    alarm_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (ring !== 1'b0) begin
      n_bad++;
      $display("FAIL alarm_reon ring=%b want 0", ring);
    end
  endtask

  task automatic test_async_reset();
    ring_up(4'd8, 6'd20);
    pulse_snooze();
    n_cmp++;
    if (snoozing !== 1'b1) begin
      n_bad++;
      $display("FAIL ar_snz snoozing=%b want 1", snoozing);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({ring, snoozing} !== 2'b00) begin
      n_bad++;
      $display("FAIL ar_drop ring/snoozing=%b want 00", {ring, snoozing});
    end
    n_cmp++;
    if ({alarm_hours, alarm_mins, alarm_pm} !== {4'd12, 6'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL ar_alarm got %0d:%0d pm%b want 12:0 pm0",
               alarm_hours, alarm_mins, alarm_pm);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    tick = 1'b0;
    hours = 4'd1;
    mins = 6'd0;
    pm = 1'b0;
    alarm_on = 1'b1;
    alarm_set_en = 1'b0;
    alarm_set_hours = 4'd0;
    alarm_set_mins = 6'd0;
    alarm_set_pm = 1'b0;
    snooze = 1'b0;
    dismiss = 1'b0;
    test_reset();
    test_match();
    test_timeout();
    test_snooze();
    test_snooze_limit();
    test_set_path();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
